// File: rtl/dither_rgb_stream.sv
// Per-channel 1-D error-diffusion colour quantizer with a registered valid/ready output stage.
// Optional macro DITHER_NOISE_EN replaces the fixed rounding threshold with LFSR noise.
module dither_rgb_stream #(
  parameter int N_CH   = 3,
  parameter int IN_W   = 8,
  parameter int OUT_W  = 4,
  parameter int THRESH = 2 ** (IN_W - OUT_W - 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_line_start,
  input  logic [N_CH*IN_W-1:0]    in_color,
  input  logic                    dither_en,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N_CH*OUT_W-1:0]   out_color
);

  localparam int DROP  = IN_W - OUT_W;
  localparam int SUM_W = IN_W + 2;
  localparam int ERR_W = DROP + 1;

  localparam logic signed [SUM_W-1:0] QMAX = SUM_W'((1 << OUT_W) - 1);
  localparam logic signed [SUM_W-1:0] EMAX = SUM_W'((1 << DROP) - 1);
  localparam logic signed [SUM_W-1:0] EMIN = -SUM_W'(1 << DROP);
  localparam logic signed [ERR_W-1:0] EMAX_E = ERR_W'((1 << DROP) - 1);
  localparam logic signed [ERR_W-1:0] EMIN_E = -ERR_W'(1 << DROP);

  logic                     accept;
  logic                     use_err;
  logic [DROP-1:0]          thr;
  logic [N_CH*OUT_W-1:0]    q_all;
  logic signed [ERR_W-1:0]  err_reg  [N_CH];
  logic signed [ERR_W-1:0]  err_next [N_CH];

  assign in_ready = out_ready | ~out_valid;
  assign accept   = in_valid & in_ready;
  assign use_err  = dither_en & ~in_line_start;

`ifdef DITHER_NOISE_EN
  logic [15:0] lfsr_reg;
  logic        lfsr_fb;

  assign lfsr_fb = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];
  assign thr     = (lfsr_reg[DROP-1:0] == '0) ? DROP'(1) : lfsr_reg[DROP-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_reg <= 16'hACE1;
    end else if (accept) begin
      lfsr_reg <= {lfsr_reg[14:0], lfsr_fb};
    end
  end
`else
  assign thr = DROP'(THRESH);
`endif

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [IN_W-1:0]          pix;
      logic signed [SUM_W-1:0]  e_ext;
      logic signed [SUM_W-1:0]  sum;
      logic signed [SUM_W-1:0]  q_raw;
      logic signed [SUM_W-1:0]  err_full;
      logic [OUT_W-1:0]         q;
      logic signed [ERR_W-1:0]  err_n;

      assign pix   = in_color[gi*IN_W +: IN_W];
      assign e_ext = use_err ? {{(SUM_W-ERR_W){err_reg[gi][ERR_W-1]}}, err_reg[gi]} : '0;
      assign sum   = $signed({2'b00, pix}) + e_ext;
      assign q_raw = (sum >>> DROP) + $signed({{(SUM_W-1){1'b0}}, (sum[DROP-1:0] >= thr)});

      always_comb begin
        q        = '0;
        err_n    = '0;
        err_full = '0;
        if (!dither_en) begin
          q = pix[IN_W-1:DROP];
        end else if (sum[SUM_W-1]) begin
          // Negative corrected value: emit black and carry the whole deficit.
          q     = '0;
          err_n = sum[ERR_W-1:0];
        end else begin
          q        = (q_raw > QMAX) ? QMAX[OUT_W-1:0] : q_raw[OUT_W-1:0];
          err_full = sum - $signed({2'b00, q, {DROP{1'b0}}});
          if (err_full > EMAX)      err_n = EMAX_E;
          else if (err_full < EMIN) err_n = EMIN_E;
          else                      err_n = err_full[ERR_W-1:0];
        end
      end

      assign q_all[gi*OUT_W +: OUT_W] = q;
      assign err_next[gi]             = err_n;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_color <= '0;
      for (int c = 0; c < N_CH; c++) err_reg[c] <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_color <= q_all;
      for (int c = 0; c < N_CH; c++) err_reg[c] <= err_next[c];
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dither_rgb_stream.sv
// Directed bench for dither_rgb_stream (default build, threshold 8, 8->4 bits, 3 channels).
module tb_dither_rgb_stream;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_line_start;
  logic [23:0] in_color;
  logic        dither_en;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_color;

  int errors = 0;
  int checks = 0;

  dither_rgb_stream dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_line_start (in_line_start),
    .in_color      (in_color),
    .dither_en     (dither_en),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_color     (out_color)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h (%0d) expected 0x%0h (%0d)", tag, obs, obs, exp, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  function automatic logic [11:0] rep(input logic [3:0] q);
    return {q, q, q};
  endfunction

  // Present one pixel, clock it in, then check the registered output.
  task automatic px(input string tag, input logic [23:0] col, input logic ls, input logic [11:0] exp);
    in_valid      = 1'b1;
    in_color      = col;
    in_line_start = ls;
    @(posedge clk); #1;
    check({tag, " valid"}, int'(out_valid), 1);
    check({tag, " color"}, int'(out_color), int'(exp));
  endtask

  task automatic idle_cycle(input logic ls);
    in_valid      = 1'b0;
    in_line_start = ls;
    @(posedge clk); #1;
    in_line_start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_line_start = 1'b0;
    in_color = '0; dither_en = 1'b1; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", int'(out_valid), 0);
    check("reset out_color", int'(out_color), 0);
    check("reset err0", int'(dut.err_reg[0]), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post-reset in_ready", int'(in_ready), 1);

    // 0x18 on all channels: 2,1,2,1,...
    for (int i = 0; i < 6; i++)
      px($sformatf("flat18 p%0d", i), 24'h181818, (i == 0), rep((i % 2 == 0) ? 4'd2 : 4'd1));

    // 0x07: 0,1,0,1,... with err -2 after the second pixel
    for (int i = 0; i < 8; i++) begin
      px($sformatf("flat07 p%0d", i), 24'h070707, (i == 0), rep((i % 2 == 0) ? 4'd0 : 4'd1));
      if (i == 1) check("flat07 err after p1", int'(dut.err_reg[0]), -2);
    end

    // 0xFF: saturated output, error clamps at 15
    for (int i = 0; i < 3; i++) begin
      px($sformatf("flatFF p%0d", i), 24'hFFFFFF, (i == 0), rep(4'hF));
      check($sformatf("flatFF err p%0d", i), int'(dut.err_reg[2]), 15);
    end

    // Mixed channels: R=0xFF (ch0), G=0x00, B=0x18
    for (int i = 0; i < 4; i++)
      px($sformatf("mixed p%0d", i), 24'h1800FF, (i == 0),
         {((i % 2 == 0) ? 4'd2 : 4'd1), 4'd0, 4'hF});
    check("mixed err G", int'(dut.err_reg[1]), 0);

    // Backpressure mid-line
    px("bp p0", 24'h181818, 1'b1, rep(4'd2));
    px("bp p1", 24'h181818, 1'b0, rep(4'd1));
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("bp stall%0d in_ready", i), int'(in_ready), 0);
      @(posedge clk); #1;
      check($sformatf("bp stall%0d valid", i), int'(out_valid), 1);
      check($sformatf("bp stall%0d color", i), int'(out_color), int'(rep(4'd1)));
    end
    check("bp stall err held", int'(dut.err_reg[0]), 0);
    out_ready = 1'b1;
    px("bp resume p2", 24'h181818, 1'b0, rep(4'd2));
    px("bp resume p3", 24'h181818, 1'b0, rep(4'd1));

    // Line start without valid is ignored; error survives idle cycles
    px("ls-idle p0", 24'h181818, 1'b0, rep(4'd2));
    idle_cycle(1'b1);
    check("idle out_valid", int'(out_valid), 0);
    px("ls-idle p1", 24'h181818, 1'b0, rep(4'd1));

    // Truncation mode
    dither_en = 1'b0;
    for (int i = 0; i < 3; i++)
      px($sformatf("trunc p%0d", i), 24'h181818, 1'b0, rep(4'd1));
    check("trunc err", int'(dut.err_reg[0]), 0);

    // Reset mid-line discards the in-flight pixel and clears error
    dither_en = 1'b1;
    px("prerst p0", 24'h181818, 1'b0, rep(4'd2));
    check("prerst err", int'(dut.err_reg[0]), -8);
    rst = 1'b1; in_valid = 1'b1; in_line_start = 1'b1;
    @(posedge clk); #1;
    check("rst out_valid", int'(out_valid), 0);
    check("rst err", int'(dut.err_reg[0]), 0);
    rst = 1'b0;
    px("postrst p0", 24'h181818, 1'b0, rep(4'd2));
    idle_cycle(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dither_rgb_stream.md
Name: dither_rgb_stream

Overview:
- Per-channel 1-D error-diffusion quantizer for the VGA colour path.
- Reduces N_CH channels of IN_W-bit colour to OUT_W bits each. Each channel carries its own signed error accumulator.
- Registered valid/ready pipeline stage. Sits between the frame/colour source and the VGA DAC pin driver.
- Error is cleared at every line start, so no error bleeds across blanking.

Parameters:
- N_CH, 3, number of colour channels (R,G,B packed, channel 0 in LSBs)
- IN_W, 8, input bits per channel
- OUT_W, 4, output bits per channel; DROP = IN_W-OUT_W, must be >= 2
- THRESH, 2**(DROP-1), round-up threshold applied to the low DROP bits of the corrected value

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  input pixel valid
- in_ready  out  1  stage can accept a pixel
- in_line_start  in  1  qualifies the first visible pixel of a line; error treated as 0 for this pixel
- in_color  in  N_CH*IN_W  packed input colour
- dither_en  in  1  1 = error diffusion; 0 = plain truncation, error held at 0
- out_valid  out  1  output pixel valid
- out_ready  in  1  downstream accepts
- out_color  out  N_CH*OUT_W  packed quantized colour

Behaviour:
- Reset: out_valid=0, out_color=0, all error registers=0, LFSR=16'hACE1 when the optional feature is present. in_ready=1 in the cycle after reset releases.
- in_ready = out_ready | ~out_valid, combinational. Accept = in_valid & in_ready.
- Output register loads on accept, giving latency 1 cycle.
- If out_ready=1 and no accept, out_valid drops to 0.
- While out_valid=1 and out_ready=0, out_color is held stable. Error and LFSR do not change.
- Per channel c, on accept:
  - e = (in_line_start | ~dither_en) ? 0 : err[c]
  - sum = in + e, signed, width IN_W+2
  - lo = sum[DROP-1:0]
  - q_raw = (sum >>> DROP) + (lo >= thr)
  - q = clamp(q_raw, 0, 2**OUT_W-1)
  - err_next = sum - q*2**DROP, saturated to [-(2**DROP), 2**DROP-1]
  - sum < 0: q=0 and err_next=sum.
- dither_en=0: q = in[IN_W-1:DROP] (pure truncation); err[c] loads 0.
- thr = THRESH unless the optional feature is enabled.
- err[c] updates only on accept. It is never modified during stalls or idle cycles.
- in_line_start without in_valid: ignored.
- in_line_start with accept: error for that pixel is 0; err_next is computed normally.
- Simultaneous accept and downstream handshake: new pixel replaces the old one, out_valid stays 1, full throughput.
- rst asserted mid-stream: the in-flight output pixel is discarded (out_valid=0 next cycle) and errors are cleared.
- Channels are fully independent. No cross-channel error.

Optional Feature:
- Macro DITHER_NOISE_EN.
- Defined:
  - 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 16'hACE1 on reset.
  - Advances once per accept.
  - thr = LFSR[DROP-1:0], with 0 replaced by 1. The same thr is used for all channels.
  - Breaks up periodic patterns on flat areas.
- Undefined: no LFSR logic; thr = THRESH constant.

Test Plan:
- Defaults, dither_en=1, every channel 0x18, in_line_start on first pixel, out_ready=1 → outputs 2,1,2,1,... per channel, one per cycle after 1-cycle latency.
- Every channel 0x07 from line start → out sequence 0,1,0,1,0,1,0,1; err after 2nd pixel = -2.
- Every channel 0xFF for 3 pixels → out 0xF each time; err saturates to 15 and never exceeds it.
- Channel R=0xFF, G=0x00, B=0x18 → R always 0xF, G always 0, B alternates 2,1. Confirms channel independence.
- Backpressure: out_ready=0 for 3 cycles mid-line:
  - in_ready=0 for those cycles
  - out_color constant
  - resuming continues the 2,1 pattern without a skipped or repeated error step.
- dither_en=0 with input 0x18, then in_line_start plus rst mid-line:
  - output 0x1 constant with dither_en=0
  - after rst: out_valid=0 next cycle, first post-reset pixel 0x18 → 2.
